// File: rtl/gfx_pkg.sv
// Shared graphics definitions: depth-function encodings and the depth compare helper.
package gfx_pkg;

  localparam logic [2:0] Z_NEVER    = 3'd0;
  localparam logic [2:0] Z_LESS     = 3'd1;
  localparam logic [2:0] Z_EQUAL    = 3'd2;
  localparam logic [2:0] Z_LEQUAL   = 3'd3;
  localparam logic [2:0] Z_GREATER  = 3'd4;
  localparam logic [2:0] Z_NOTEQUAL = 3'd5;
  localparam logic [2:0] Z_GEQUAL   = 3'd6;
  localparam logic [2:0] Z_ALWAYS   = 3'd7;

  // Operands are zero-extended by callers, so any Z width up to 64 bits compares unsigned.
  localparam int unsigned Z_CMP_WIDTH = 64;

  // Evaluates the depth function with a = incoming Z, b = stored Z.
  function automatic logic z_compare(input logic [2:0] func,
                                     input logic [Z_CMP_WIDTH-1:0] a,
                                     input logic [Z_CMP_WIDTH-1:0] b);
    logic r;
    case (func)
      Z_NEVER:    r = 1'b0;
      Z_LESS:     r = (a <  b);
      Z_EQUAL:    r = (a == b);
      Z_LEQUAL:   r = (a <= b);
      Z_GREATER:  r = (a >  b);
      Z_NOTEQUAL: r = (a != b);
      Z_GEQUAL:   r = (a >= b);
      default:    r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: q presents the head entry whenever empty is low.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrreq,
  input  logic [WIDTH-1:0]      data,
  input  logic                  rdreq,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   usedw
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [DEPTH_LOG2-1:0] next_ptr(input logic [DEPTH_LOG2-1:0] p);
    return (p == DEPTH_LOG2'(DEPTH - 1)) ? '0 : p + DEPTH_LOG2'(1);
  endfunction

  assign do_push = wrreq && !full;
  assign do_pop  = rdreq && !empty;
  assign empty   = (usedw == '0);
  assign full    = (usedw == (DEPTH_LOG2 + 1)'(DEPTH));
  assign q       = mem[rd_ptr];

  // Storage array write; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   usedw <= usedw + (DEPTH_LOG2 + 1)'(1);
        2'b01:   usedw <= usedw - (DEPTH_LOG2 + 1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

endmodule

// File: rtl/z_test_fifo.sv
// Depth-test queue: holds pixel groups while their Z reads are outstanding, tests
// each pixel against the returned Z word and forwards groups with any surviving pixel.
// Optional build macro Z_TEST_STATS_EN adds pass/fail pixel counters.
module z_test_fifo
  import gfx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 5,
  parameter int unsigned PIXELS          = 2,
  parameter int unsigned Z_WIDTH         = 32,
  parameter int unsigned COLOR_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH      = 29
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          z_active,
  input  logic [2:0]                    z_func,
  input  logic [PIXELS*Z_WIDTH-1:0]     read_readdata,
  input  logic                          read_readdatavalid,
  input  logic                          enqueue,
  input  logic [ADDR_WIDTH-1:0]         color_address,
  input  logic [ADDR_WIDTH-1:0]         z_address,
  input  logic [PIXELS*COLOR_WIDTH-1:0] color,
  input  logic [PIXELS*Z_WIDTH-1:0]     z,
  input  logic [PIXELS-1:0]             pixel_active,
  output logic [FIFO_DEPTH_LOG2:0]      size,
  output logic                          full,
  output logic                          overflow,
  input  logic                          write_ready,
  output logic                          write_enqueue,
  output logic [ADDR_WIDTH-1:0]         write_color_address,
  output logic [PIXELS*COLOR_WIDTH-1:0] write_color,
  output logic [ADDR_WIDTH-1:0]         write_z_address,
  output logic [PIXELS*Z_WIDTH-1:0]     write_z,
  output logic [PIXELS-1:0]             write_pixel_active
`ifdef Z_TEST_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [31:0]                   stat_pass,
  output logic [31:0]                   stat_fail
`endif
);

  localparam int unsigned ZW   = PIXELS * Z_WIDTH;
  localparam int unsigned CW   = PIXELS * COLOR_WIDTH;
  localparam int unsigned PIXW = 2 * ADDR_WIDTH + CW + ZW + PIXELS;

  logic [PIXW-1:0]          pix_q;
  logic                     pix_empty;
  logic [ADDR_WIDTH-1:0]    q_color_address;
  logic [ADDR_WIDTH-1:0]    q_z_address;
  logic [CW-1:0]            q_color;
  logic [ZW-1:0]            q_z;
  logic [PIXELS-1:0]        q_active;

  logic [ZW-1:0]            z_q;
  logic                     z_empty;
  logic                     z_full;
  logic [FIFO_DEPTH_LOG2:0] z_usedw_unused;
  logic                     z_push;

  logic                     stage_free;
  logic                     pop;
  logic                     keep;
  logic [PIXELS-1:0]        new_mask;

  sync_fifo #(
    .WIDTH      (PIXW),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_pixel_fifo (
    .clock (clock),
    .reset (reset),
    .wrreq (enqueue),
    .data  ({color_address, z_address, color, z, pixel_active}),
    .rdreq (pop),
    .q     (pix_q),
    .empty (pix_empty),
    .full  (full),
    .usedw (size)
  );

  assign z_push = read_readdatavalid && z_active;

  sync_fifo #(
    .WIDTH      (ZW),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_z_fifo (
    .clock (clock),
    .reset (reset),
    .wrreq (z_push),
    .data  (read_readdata),
    .rdreq (pop && z_active),
    .q     (z_q),
    .empty (z_empty),
    .full  (z_full),
    .usedw (z_usedw_unused)
  );

  assign {q_color_address, q_z_address, q_color, q_z, q_active} = pix_q;

  assign stage_free = !write_enqueue || write_ready;
  assign pop        = !pix_empty && (!z_active || !z_empty) && stage_free;
  assign keep       = |new_mask;

  // Per-pixel depth test on the head group; pixels always survive when testing is off.
  always_comb begin
    new_mask = '0;
    for (int unsigned i = 0; i < PIXELS; i++) begin
      new_mask[i] = q_active[i] &&
                    (!z_active ||
                     z_compare(z_func,
                               Z_CMP_WIDTH'(q_z[i*Z_WIDTH +: Z_WIDTH]),
                               Z_CMP_WIDTH'(z_q[i*Z_WIDTH +: Z_WIDTH])));
    end
  end

  // Output register: loads on a kept pop, holds while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_enqueue       <= 1'b0;
      write_pixel_active  <= '0;
      write_color_address <= '0;
      write_color         <= '0;
      write_z_address     <= '0;
      write_z             <= '0;
    end else if (stage_free) begin
      write_enqueue <= pop && keep;
      if (pop && keep) begin
        write_color_address <= q_color_address;
        write_color         <= q_color;
        write_z_address     <= q_z_address;
        write_z             <= q_z;
        write_pixel_active  <= new_mask;
      end
    end
  end

  // Sticky overflow on any push attempt into a full queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if ((enqueue && full) || (z_push && z_full)) begin
      overflow <= 1'b1;
    end
  end

`ifdef Z_TEST_STATS_EN
  logic [31:0] pass_cnt;
  logic [31:0] fail_cnt;

  // Count surviving and rejected active pixels of the head group.
  always_comb begin
    pass_cnt = '0;
    fail_cnt = '0;
    for (int unsigned i = 0; i < PIXELS; i++) begin
      if (q_active[i]) begin
        if (new_mask[i]) pass_cnt = pass_cnt + 32'd1;
        else             fail_cnt = fail_cnt + 32'd1;
      end
    end
  end

  // Wrapping statistics counters; clear takes priority over accumulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (stat_clear) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (pop) begin
      stat_pass <= stat_pass + pass_cnt;
      stat_fail <= stat_fail + fail_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_z_test_fifo.sv
// Self-checking bench for z_test_fifo: queue-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_z_test_fifo;

  localparam int DEPTH = 32;
  localparam int AW    = 29;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          z_active = 1'b0;
  logic [2:0]    z_func = 3'd7;
  logic [63:0]   read_readdata = '0;
  logic          read_readdatavalid = 1'b0;
  logic          enqueue = 1'b0;
  logic [AW-1:0] color_address = '0;
  logic [AW-1:0] z_address = '0;
  logic [63:0]   color = '0;
  logic [63:0]   z = '0;
  logic [1:0]    pixel_active = '0;
  logic [5:0]    size;
  logic          full;
  logic          overflow;
  logic          write_ready = 1'b1;
  logic          write_enqueue;
  logic [AW-1:0] write_color_address;
  logic [63:0]   write_color;
  logic [AW-1:0] write_z_address;
  logic [63:0]   write_z;
  logic [1:0]    write_pixel_active;
`ifdef Z_TEST_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_pass;
  logic [31:0]   stat_fail;
`endif

  int checks = 0;
  int fails  = 0;

  z_test_fifo #(
    .FIFO_DEPTH      (32),
    .FIFO_DEPTH_LOG2 (5),
    .PIXELS          (2),
    .Z_WIDTH         (32),
    .COLOR_WIDTH     (32),
    .ADDR_WIDTH      (29)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .z_active            (z_active),
    .z_func              (z_func),
    .read_readdata       (read_readdata),
    .read_readdatavalid  (read_readdatavalid),
    .enqueue             (enqueue),
    .color_address       (color_address),
    .z_address           (z_address),
    .color               (color),
    .z                   (z),
    .pixel_active        (pixel_active),
    .size                (size),
    .full                (full),
    .overflow            (overflow),
    .write_ready         (write_ready),
    .write_enqueue       (write_enqueue),
    .write_color_address (write_color_address),
    .write_color         (write_color),
    .write_z_address     (write_z_address),
    .write_z             (write_z),
    .write_pixel_active  (write_pixel_active)
`ifdef Z_TEST_STATS_EN
    ,
    .stat_clear          (stat_clear),
    .stat_pass           (stat_pass),
    .stat_fail           (stat_fail)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] ca;
    logic [AW-1:0] za;
    logic [63:0]   col;
    logic [63:0]   zz;
    logic [1:0]    act;
  } grp_t;

  grp_t        pq[$];
  logic [63:0] zq[$];
  logic        m_valid = 1'b0;
  logic        m_ovf   = 1'b0;
  grp_t        m_out;

  function automatic logic zpass(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return 1'b0;
      3'd1: return a < b;
      3'd2: return a == b;
      3'd3: return a <= b;
      3'd4: return a > b;
      3'd5: return a != b;
      3'd6: return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    bit          p_full, zf, free;
    grp_t        g, ng;
    logic [63:0] mem;
    logic [1:0]  nm;
    if (reset) begin
      pq.delete();
      zq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      p_full = (pq.size() == DEPTH);
      zf     = (zq.size() == DEPTH);
      free   = !m_valid || write_ready;
      if (free) begin
        m_valid = 1'b0;
        if (pq.size() > 0 && (!z_active || zq.size() > 0)) begin
          g   = pq.pop_front();
          mem = '0;
          if (z_active) mem = zq.pop_front();
          for (int i = 0; i < 2; i++)
            nm[i] = g.act[i] && (!z_active || zpass(z_func, g.zz[i*32 +: 32], mem[i*32 +: 32]));
          if (nm != 2'b00) begin
            m_valid = 1'b1;
            m_out   = g;
            m_out.act = nm;
          end
        end
      end
      if (enqueue) begin
        if (p_full) m_ovf = 1'b1;
        else begin
          ng.ca = color_address; ng.za = z_address; ng.col = color;
          ng.zz = z; ng.act = pixel_active;
          pq.push_back(ng);
        end
      end
      if (read_readdatavalid && z_active) begin
        if (zf) m_ovf = 1'b1;
        else zq.push_back(read_readdata);
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clock) begin
    #1;
    chk("size", 128'(size), 128'(pq.size()));
    chk("full", 128'(full), 128'(pq.size() == DEPTH));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("write_enqueue", 128'(write_enqueue), 128'(m_valid));
    if (m_valid) begin
      chk("write_color_address", 128'(write_color_address), 128'(m_out.ca));
      chk("write_z_address", 128'(write_z_address), 128'(m_out.za));
      chk("write_color", 128'(write_color), 128'(m_out.col));
      chk("write_z", 128'(write_z), 128'(m_out.zz));
      chk("write_pixel_active", 128'(write_pixel_active), 128'(m_out.act));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_grp(input int k, input logic [63:0] zz, input logic [1:0] act);
    enqueue       = 1'b1;
    color_address = AW'(32'h100 + k);
    z_address     = AW'(32'h200 + k);
    color         = {32'hC000 + 32'(k), 32'hA000 + 32'(k)};
    z             = zz;
    pixel_active  = act;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!write_enqueue && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!write_enqueue) chk({name, "_timeout"}, 128'(0), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_size", 128'(size), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_write_enqueue", 128'(write_enqueue), 128'(0));
    chk("rst_write_pixel_active", 128'(write_pixel_active), 128'(0));
    reset = 1'b0;

    // Test off: passthrough, two-cycle latency.
    @(negedge clock);
    z_active = 1'b0; write_ready = 1'b1;
    drive_grp(1, {32'd7, 32'd3}, 2'b11);
    @(negedge clock);
    enqueue = 1'b0;
    chk("t1_latency1", 128'(write_enqueue), 128'(0));
    @(negedge clock);
    chk("t1_valid", 128'(write_enqueue), 128'(1));
    chk("t1_mask", 128'(write_pixel_active), 128'(2'b11));
    chk("t1_color", 128'(write_color), 128'({32'hC001, 32'hA001}));
    chk("t1_caddr", 128'(write_color_address), 128'(29'h101));
    chk("t1_z", 128'(write_z), 128'({32'd7, 32'd3}));
    @(negedge clock);
    chk("t1_done", 128'(write_enqueue), 128'(0));

    // LEQUAL: pixel0 10<=10 passes, pixel1 20<=15 fails.
    z_active = 1'b1; z_func = 3'd3;
    drive_grp(2, {32'd20, 32'd10}, 2'b11);
    @(negedge clock);
    enqueue = 1'b0;
    read_readdata = {32'd15, 32'd10}; read_readdatavalid = 1'b1;
    @(negedge clock);
    read_readdatavalid = 1'b0;
    wait_valid("t2", 10);
    chk("t2_mask", 128'(write_pixel_active), 128'(2'b01));
    chk("t2_z", 128'(write_z), 128'({32'd20, 32'd10}));
    @(negedge clock);

    // LESS with equal Z: whole group dropped.
    z_func = 3'd1;
    drive_grp(3, {32'd5, 32'd5}, 2'b11);
    @(negedge clock);
    enqueue = 1'b0;
    read_readdata = {32'd5, 32'd5}; read_readdatavalid = 1'b1;
    @(negedge clock);
    read_readdatavalid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("t3_no_output", 128'(write_enqueue), 128'(0));
    end
    chk("t3_size", 128'(size), 128'(0));

    // Backpressure: four groups, consumer stalled for ten cycles.
    z_active = 1'b0; write_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_grp(10 + k, 64'(k), 2'b10);
      @(negedge clock);
    end
    enqueue = 1'b0;
    repeat (10) begin
      chk("t4_hold_size", 128'(size), 128'(3));
      chk("t4_hold_valid", 128'(write_enqueue), 128'(1));
      chk("t4_hold_color", 128'(write_color), 128'({32'hC00A, 32'hA00A}));
      @(negedge clock);
    end
    write_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      chk("t4_b2b_valid", 128'(write_enqueue), 128'(1));
      chk("t4_b2b_order", 128'(write_color_address), 128'(AW'(32'h10A + k)));
    end
    @(negedge clock);
    chk("t4_drained", 128'(write_enqueue), 128'(0));

    // Overflow: no Z returns, so nothing drains.
    z_active = 1'b1; z_func = 3'd7;
    for (int k = 0; k < DEPTH + 1; k++) begin
      if (k == DEPTH) begin
        chk("t5_full", 128'(full), 128'(1));
        chk("t5_no_ovf_yet", 128'(overflow), 128'(0));
      end
      drive_grp(k, 64'(k), 2'b11);
      @(negedge clock);
    end
    chk("t5_size", 128'(size), 128'(DEPTH));
    chk("t5_overflow", 128'(overflow), 128'(1));
    @(negedge clock);
    chk("t5_sticky", 128'(overflow), 128'(1));
    reset = 1'b1;
    #1;
    chk("t5_rst_size", 128'(size), 128'(0));
    chk("t5_rst_ovf", 128'(overflow), 128'(0));
    chk("t5_rst_valid", 128'(write_enqueue), 128'(0));
    @(negedge clock);
    enqueue = 1'b0;
    reset = 1'b0;
    @(negedge clock);

`ifdef Z_TEST_STATS_EN
    // GREATER: 9>4 passes, 1>4 fails.
    chk("t6_pass_rst", 128'(stat_pass), 128'(0));
    z_active = 1'b1; z_func = 3'd4;
    drive_grp(6, {32'd1, 32'd9}, 2'b11);
    @(negedge clock);
    enqueue = 1'b0;
    read_readdata = {32'd4, 32'd4}; read_readdatavalid = 1'b1;
    @(negedge clock);
    read_readdatavalid = 1'b0;
    wait_valid("t6", 10);
    chk("t6_mask", 128'(write_pixel_active), 128'(2'b01));
    chk("t6_stat_pass", 128'(stat_pass), 128'(1));
    chk("t6_stat_fail", 128'(stat_fail), 128'(1));
    stat_clear = 1'b1;
    @(negedge clock);
    stat_clear = 1'b0;
    chk("t6_clr_pass", 128'(stat_pass), 128'(0));
    chk("t6_clr_fail", 128'(stat_fail), 128'(0));
    @(negedge clock);
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
